serial_word_feeder: RTL and testbench

//  Upstream feeder for the serial "101" pattern-detector FSM.

---
 rtl/serial_word_feeder.sv | 96 +++++++++
 tb/tb_serial_word_feeder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for the "101" pattern detector: valid/ready word intake,
// one bit per clock on x_out, with a 1-entry pending buffer for gapless streaming.
module serial_word_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_active,
  output logic             word_done
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [WIDTH-1:0] pbuf, pbuf_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             pfull, pfull_nx;
  logic             xfer;
  logic             cur_bit;
  logic [WIDTH-1:0] shifted;

  // The output end of sreg is fixed by MSB_FIRST; shifting always moves toward it.
  assign cur_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

  assign in_ready  = ~pfull;
  assign xfer      = in_valid & in_ready;
  assign x_active  = (state == SHIFT);
  assign x_out     = (state == SHIFT) ? cur_bit : IDLE_BIT;
  assign word_done = (state == SHIFT) && (cnt == '0);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      sreg  <= '0;
      pbuf  <= '0;
      cnt   <= '0;
      pfull <= 1'b0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      pbuf  <= pbuf_nx;
      cnt   <= cnt_nx;
      pfull <= pfull_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    pbuf_nx  = pbuf;
    cnt_nx   = cnt;
    pfull_nx = pfull;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          sreg_nx  = in_data;
          cnt_nx   = LAST_IDX;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          sreg_nx = shifted;
          cnt_nx  = cnt - CW'(1);
          if (xfer) begin
            pbuf_nx  = in_data;
            pfull_nx = 1'b1;
          end
        end else if (pfull) begin
          sreg_nx  = pbuf;
          cnt_nx   = LAST_IDX;
          pfull_nx = 1'b0;
        end else if (xfer) begin
          // Last-bit cycle with an empty buffer: load straight from the input.
          sreg_nx = in_data;
          cnt_nx  = LAST_IDX;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed-vector bench for serial_word_feeder: one MSB-first instance and one LSB-first
// instance, expected bit streams written out by hand.
module tb_serial_word_feeder;

  logic       clk;
  logic       aresetn;
  logic [7:0] in_data, ld;
  logic       in_valid, lv;
  logic       in_ready, x_out, x_active, word_done;
  logic       rdy_l, x_out_l, act_l, done_l;

  int n_vec = 0;
  int n_bad = 0;

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .aresetn(aresetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x_out(x_out), .x_active(x_active), .word_done(word_done)
  );

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .aresetn(aresetn), .in_data(ld), .in_valid(lv),
    .in_ready(rdy_l), .x_out(x_out_l), .x_active(act_l), .word_done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  w_a5;
  logic [23:0] s3;
  logic [15:0] s5;

  initial begin
    w_a5     = 8'hA5;
    s3       = 24'hA53C5A;
    s5       = 16'h817E;
    aresetn  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    lv       = 1'b0;
    ld       = '0;
    #2;
    check("rst_x_out", x_out, 0);
    check("rst_x_active", x_active, 0);
    check("rst_word_done", word_done, 0);
    repeat (2) @(posedge clk);
    #3 aresetn = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t1_x_out", x_out, 0);
      check("t1_x_active", x_active, 0);
      check("t1_in_ready", in_ready, 1);
      check("t1_word_done", word_done, 0);
    end

    // 2: single word A5
    in_valid = 1'b1;
    in_data  = 8'hA5;
    check("t2_ready_c0", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8) begin
        check("t2_x_out", x_out, w_a5[8-c]);
        check("t2_x_active", x_active, 1);
      end else begin
        check("t2_idle_x_out", x_out, 0);
        check("t2_idle_x_active", x_active, 0);
      end
      check("t2_word_done", word_done, c == 8);
      tick();
    end

    // 3: A5, 3C back-to-back, 5A offered from cycle 2
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    for (int c = 1; c <= 25; c++) begin
      if (c <= 24) begin
        check("t3_x_out", x_out, s3[24-c]);
        check("t3_x_active", x_active, 1);
      end else begin
        check("t3_idle_x_active", x_active, 0);
        check("t3_idle_x_out", x_out, 0);
      end
      check("t3_word_done", word_done, (c == 8) || (c == 16) || (c == 24));
      if (c <= 9) check("t3_in_ready", in_ready, (c == 1) || (c == 9));
      if (c == 1) begin
        in_valid = 1'b1;
        in_data  = 8'h3C;
      end else if (c <= 9) begin
        in_valid = 1'b1;
        in_data  = 8'h5A;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end

    // 5: word offered exactly in the last-bit cycle
    in_valid = 1'b1;
    in_data  = 8'h81;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c <= 16) begin
        check("t5_x_out", x_out, s5[16-c]);
        check("t5_x_active", x_active, 1);
      end else begin
        check("t5_idle_x_active", x_active, 0);
      end
      check("t5_in_ready", in_ready, 1);
      check("t5_word_done", word_done, (c == 8) || (c == 16));
      in_valid = (c == 8);
      in_data  = 8'h7E;
      tick();
    end
    in_valid = 1'b0;

    // 4: LSB-first instance, word 01
    lv = 1'b1;
    ld = 8'h01;
    tick();
    lv = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check("t4_x_out", x_out_l, c == 1);
      check("t4_x_active", act_l, c <= 8);
      check("t4_word_done", done_l, c == 8);
      tick();
    end

    // 6: reset during word FF with 55 pending
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_data  = 8'h55;
    check("t6_ready_c1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t6_pending_ready", in_ready, 0);
    tick();
    tick();
    check("t6_c4_x_out", x_out, 1);
    check("t6_c4_x_active", x_active, 1);
    #2 aresetn = 1'b0;
    #1;
    check("t6_async_x_out", x_out, 0);
    check("t6_async_x_active", x_active, 0);
    check("t6_async_word_done", word_done, 0);
    check("t6_async_in_ready", in_ready, 1);
    tick();
    check("t6_hold_x_out", x_out, 0);
    check("t6_hold_word_done", word_done, 0);
    #3 aresetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("t6_post_x_active", x_active, 0);
      check("t6_post_x_out", x_out, 0);
      check("t6_post_in_ready", in_ready, 1);
      check("t6_post_word_done", word_done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
